sync_fifo_s1_sf: RTL and testbench
==================================

# sync_fifo_s1_sf

Single-clock synchronous FIFO with static status flags, used as the output-port buffer in the NoC router. It holds up to `depth` words of `width` bits and presents the head word on `data_out` (show-ahead). It exposes registered empty, almost-empty, half-full, almost-full and full flags plus an overflow/underflow error flag. Push and pop requests are active-low and act on the rising clock edge.

## Interface
Parameters:
- `width`, default 16: data word width in bits (1..256).
- `depth`, default 5: number of storage words (2..256).
- `ae_level`, default 1: almost_empty threshold in words (1..depth-1).
- `af_level`, default 1: almost_full threshold, counted as free words (1..depth-1).
- `err_mode`, default 0: 0 = error flag is sticky until reset or diag; 1 = error flag is dynamic and reflects only the previous cycle.

Ports:
- `clk`, in, 1: clock; all state changes on the rising edge.
- `rst`, in, 1: reset, asynchronous and active-high; clears pointers, count, memory and error.
- `push_req_n`, in, 1: active-low push request.
- `pop_req_n`, in, 1: active-low pop request.
- `diag_n`, in, 1: active-low diagnostic clear; tie high for normal use.
- `data_in`, in, `width`: write data.
- `empty`, out, 1: count == 0.
- `almost_empty`, out, 1: count <= ae_level.
- `half_full`, out, 1: count >= (depth+1)/2 (integer division).
- `almost_full`, out, 1: count >= depth - af_level.
- `full`, out, 1: count == depth.
- `error`, out, 1: overflow or underflow occurred.
- `data_out`, out, `width`: head-of-queue word, mem[rd_ptr].

## Operation
- Storage is a `depth`-entry register array. Write pointer, read pointer and count are registered. Pointers wrap from depth-1 to 0; depth need not be a power of 2.
- Push is accepted when push_req_n=0 and either the FIFO is not full, or it is full and a pop is accepted in the same cycle. An accepted push writes data_in to mem[wr_ptr] and increments wr_ptr.
- Pop is accepted when pop_req_n=0 and the FIFO is not empty. An accepted pop increments rd_ptr. There is no fall-through: a pop on empty is never accepted, even if a push happens in the same cycle.
- Count update: +1 on push only, -1 on pop only, unchanged on both or neither.
- Simultaneous push and pop:
  - Empty: push only, underflow.
  - Full: both are performed and count stays at depth.
  - Otherwise: both are performed.
- Overflow: push_req_n=0 while full with no accepted pop. The push is dropped and memory and pointers are unchanged.
- Underflow: pop_req_n=0 while empty. The pop is ignored.
- Error flag:
  - err_mode 0: set on overflow or underflow and held until rst or diag_n=0.
  - err_mode 1: error is the registered OR of overflow and underflow from the previous cycle.
- diag_n=0 synchronously clears pointers, count and error; memory contents are kept. diag_n takes priority over push and pop in that cycle.
- All flags are decoded from the registered count, so they are glitch-free registered outputs.

## Timing
- Reset values: empty=1, almost_empty=1, half_full=0, almost_full=0, full=0, error=0, data_out=0.
- Reset assertion takes effect immediately, with no clock needed. Reset in the middle of operation discards all contents.
- Push latency: a word pushed at edge N into an empty FIFO appears on data_out after edge N, and empty falls after the same edge. Within the same cycle data_out is combinational from mem[rd_ptr].
- Pop: the consumer samples data_out in the cycle with pop_req_n=0. After the edge, data_out shows the next word.
- Flags, count and error all change only on clock edges (except on reset). Each update is visible one edge after the request.
- Sustained push+pop at 1 word/cycle is supported at any occupancy, including full.

## Test plan
- Reset then idle: all flags at reset values, data_out=0, error=0 over 10 cycles.
- Push 0x0001..0x0005 on 5 consecutive cycles (depth 5):
  - Count 1→5; after push 1, empty=0 and almost_empty=1.
  - half_full=1 from count 3; almost_full=1 at 4; full=1 at 5; data_out=0x0001 throughout.
- At full, push 0x00AA alone: error=1 and stays (err_mode 0); contents unchanged. Then pop 5 times: data_out reads 0x0001..0x0005 in order; empty=1 after the 5th pop.
- From empty, pop_req_n=0 with push_req_n=0, data 0x1234: count=1, data_out=0x1234, error=1 (underflow).
- Full FIFO, push+pop together for 7 cycles with 0x0100.. data: full stays 1, no error, output order is preserved across the pointer wrap.
- Mid-stream rst pulse with 3 words stored: empty=1 and data_out=0 immediately. Then a push of 0xBEEF shows 0xBEEF on data_out one edge later.

Source files
------------

// File: rtl/sync_fifo_s1_sf_if.sv
// Handshake and status bundle for the sync_fifo_s1_sf router output buffer.
// The producer/consumer side is the master; the FIFO is the slave.
interface sync_fifo_s1_sf_if #(
  parameter int width = 16
);
  logic             push_req_n;
  logic             pop_req_n;
  logic             diag_n;
  logic [width-1:0] data_in;
  logic             empty;
  logic             almost_empty;
  logic             half_full;
  logic             almost_full;
  logic             full;
  logic             error;
  logic [width-1:0] data_out;

  modport master (
    output push_req_n, pop_req_n, diag_n, data_in,
    input  empty, almost_empty, half_full,
    input  almost_full, full, error, data_out
  );

  modport slave (
    input  push_req_n, pop_req_n, diag_n, data_in,
    output empty, almost_empty, half_full,
    output almost_full, full, error, data_out
  );
endinterface

// File: rtl/sync_fifo_s1_sf.sv
// Single-clock show-ahead FIFO with static status flags and error flag.
// Pointers wrap at depth-1 so depth need not be a power of two.
module sync_fifo_s1_sf #(
  parameter int width    = 16,
  parameter int depth    = 5,
  parameter int ae_level = 1,
  parameter int af_level = 1,
  parameter int err_mode = 0
) (
  input logic               clk,
  input logic               rst,
  sync_fifo_s1_sf_if.slave  bus
);
  localparam int AW = (depth > 1) ? $clog2(depth) : 1;
  localparam int CW = $clog2(depth + 1);

  localparam logic [AW-1:0] LAST = AW'(depth - 1);
  localparam logic [CW-1:0] C_FULL = CW'(depth);
  localparam logic [CW-1:0] C_AE = CW'(ae_level);
  localparam logic [CW-1:0] C_HF = CW'((depth + 1) / 2);
  localparam logic [CW-1:0] C_AF = CW'(depth - af_level);

  logic [width-1:0] mem_q [depth];
  logic [width-1:0] mem_d [depth];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             err_q, err_d;

  logic is_empty, is_full;
  logic push_ok, pop_ok;
  logic ovf, udf;

  always_comb begin
    is_empty = (cnt_q == '0);
    is_full  = (cnt_q == C_FULL);
    // A pop on empty never falls through to a same-cycle push.
    pop_ok   = !bus.pop_req_n && !is_empty;
    push_ok  = !bus.push_req_n && (!is_full || pop_ok);
    ovf      = !bus.push_req_n && is_full && !pop_ok;
    udf      = !bus.pop_req_n && is_empty;

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    err_d    = err_q;

    if (!bus.diag_n) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      err_d    = 1'b0;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q] = bus.data_in;
        wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + 1'b1;
      end
      unique case ({push_ok, pop_ok})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
      if (err_mode == 0) err_d = err_q | ovf | udf;
      else               err_d = ovf | udf;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < depth; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  assign bus.empty        = is_empty;
  assign bus.almost_empty = (cnt_q <= C_AE);
  assign bus.half_full    = (cnt_q >= C_HF);
  assign bus.almost_full  = (cnt_q >= C_AF);
  assign bus.full         = is_full;
  assign bus.error        = err_q;
  assign bus.data_out     = mem_q[rd_ptr_q];
endmodule

// File: tb/tb_sync_fifo_s1_sf.sv
// Self-checking bench for sync_fifo_s1_sf: directed table, corner
// sequences and random traffic against a queue-based model.
module tb_sync_fifo_s1_sf;
  localparam int W = 16;
  localparam int D = 5;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;

  sync_fifo_s1_sf_if #(.width(W)) bus ();

  sync_fifo_s1_sf #(
    .width(W), .depth(D), .ae_level(1),
    .af_level(1), .err_mode(0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  logic [W-1:0] q[$];
  bit           m_err;
  bit           dout_known;

  typedef struct {
    bit         pn, qn, dn;
    logic [W-1:0] din;
    bit         e, ae, hf, af, f, er;
    bit         dchk;
    logic [W-1:0] dout;
  } vec_t;

  vec_t tbl[14];

  task automatic chk1(string name, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0b exp=%0b", name, act, exp);
    end
  endtask

  task automatic chkw(string name, logic [W-1:0] act, logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic check_model(string tag);
    int n;
    n = q.size();
    chk1({tag, " empty"}, bus.empty, n == 0);
    chk1({tag, " almost_empty"}, bus.almost_empty, n <= 1);
    chk1({tag, " half_full"}, bus.half_full, n >= (D + 1) / 2);
    chk1({tag, " almost_full"}, bus.almost_full, n >= D - 1);
    chk1({tag, " full"}, bus.full, n == D);
    chk1({tag, " error"}, bus.error, m_err);
    if (n > 0) chkw({tag, " data_out"}, bus.data_out, q[0]);
    else if (dout_known) chkw({tag, " data_out"}, bus.data_out, '0);
  endtask

  task automatic model_step(bit pn, bit qn, bit dn, logic [W-1:0] d);
    int n;
    bit pop_ok, push_ok, ovf, udf;
    n = q.size();
    pop_ok  = !qn && n > 0;
    push_ok = !pn && (n < D || pop_ok);
    ovf     = !pn && n == D && !pop_ok;
    udf     = !qn && n == 0;
    if (!dn) begin
      q.delete();
      m_err = 1'b0;
      dout_known = 1'b0;
    end else begin
      if (pop_ok) void'(q.pop_front());
      if (push_ok) begin
        q.push_back(d);
        dout_known = 1'b0;
      end
      m_err = m_err | ovf | udf;
    end
  endtask

  task automatic step(bit pn, bit qn, bit dn, logic [W-1:0] d);
    bus.push_req_n = pn;
    bus.pop_req_n  = qn;
    bus.diag_n     = dn;
    bus.data_in    = d;
    @(posedge clk);
    model_step(pn, qn, dn, d);
    #1;
    bus.push_req_n = 1'b1;
    bus.pop_req_n  = 1'b1;
    bus.diag_n     = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.push_req_n = 1'b1;
    bus.pop_req_n  = 1'b1;
    bus.diag_n     = 1'b1;
    bus.data_in    = '0;
    q.delete();
    m_err = 1'b0;
    dout_known = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    // pn qn dn din | e ae hf af f er | dchk dout
    tbl[0]  = '{0,1,1,16'h0001, 0,1,0,0,0,0, 1,16'h0001};
    tbl[1]  = '{0,1,1,16'h0002, 0,0,0,0,0,0, 1,16'h0001};
    tbl[2]  = '{0,1,1,16'h0003, 0,0,1,0,0,0, 1,16'h0001};
    tbl[3]  = '{0,1,1,16'h0004, 0,0,1,1,0,0, 1,16'h0001};
    tbl[4]  = '{0,1,1,16'h0005, 0,0,1,1,1,0, 1,16'h0001};
    tbl[5]  = '{0,1,1,16'h00AA, 0,0,1,1,1,1, 1,16'h0001};
    tbl[6]  = '{1,0,1,16'h0000, 0,0,1,1,0,1, 1,16'h0002};
    tbl[7]  = '{1,0,1,16'h0000, 0,0,1,0,0,1, 1,16'h0003};
    tbl[8]  = '{1,0,1,16'h0000, 0,0,0,0,0,1, 1,16'h0004};
    tbl[9]  = '{1,0,1,16'h0000, 0,1,0,0,0,1, 1,16'h0005};
    tbl[10] = '{1,0,1,16'h0000, 1,1,0,0,0,1, 0,16'h0000};
    tbl[11] = '{0,1,0,16'h0777, 1,1,0,0,0,0, 0,16'h0000};
    tbl[12] = '{0,0,1,16'h1234, 0,1,0,0,0,1, 1,16'h1234};
    tbl[13] = '{1,1,0,16'h0000, 1,1,0,0,0,0, 0,16'h0000};

    do_reset();
    check_model("reset");
    for (int i = 0; i < 10; i++) begin
      step(1, 1, 1, '0);
      check_model($sformatf("idle%0d", i));
    end

    for (int i = 0; i < 14; i++) begin
      step(tbl[i].pn, tbl[i].qn, tbl[i].dn, tbl[i].din);
      chk1($sformatf("tbl%0d empty", i), bus.empty, tbl[i].e);
      chk1($sformatf("tbl%0d almost_empty", i), bus.almost_empty, tbl[i].ae);
      chk1($sformatf("tbl%0d half_full", i), bus.half_full, tbl[i].hf);
      chk1($sformatf("tbl%0d almost_full", i), bus.almost_full, tbl[i].af);
      chk1($sformatf("tbl%0d full", i), bus.full, tbl[i].f);
      chk1($sformatf("tbl%0d error", i), bus.error, tbl[i].er);
      if (tbl[i].dchk)
        chkw($sformatf("tbl%0d data_out", i), bus.data_out, tbl[i].dout);
    end

    // Full FIFO with sustained push+pop across the pointer wrap.
    do_reset();
    for (int i = 0; i < D; i++) step(0, 1, 1, W'(16'h0100 + i));
    check_model("fill");
    for (int i = 0; i < 7; i++) begin
      chkw($sformatf("stream%0d pre data_out", i), bus.data_out,
           W'(16'h0100 + i));
      step(0, 0, 1, W'(16'h0100 + D + i));
      check_model($sformatf("stream%0d", i));
    end

    // Asynchronous reset mid-operation with 3 words stored.
    do_reset();
    for (int i = 0; i < 3; i++) step(0, 1, 1, W'(16'h0A00 + i));
    check_model("pre_rst");
    #2 rst = 1'b1;
    #1;
    chk1("async_rst empty", bus.empty, 1'b1);
    chkw("async_rst data_out", bus.data_out, '0);
    q.delete();
    m_err = 1'b0;
    dout_known = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    step(0, 1, 1, 16'hBEEF);
    chkw("post_rst data_out", bus.data_out, 16'hBEEF);
    check_model("post_rst");

    // Random traffic against the queue model.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      int  pct;
      bit  pn, qn, dn;
      pct = (i < 200) ? 70 : (i < 400) ? 30 : 50;
      pn = ($urandom_range(0, 99) < pct) ? 1'b0 : 1'b1;
      qn = ($urandom_range(0, 99) < 100 - pct) ? 1'b0 : 1'b1;
      dn = ($urandom_range(0, 59) == 0) ? 1'b0 : 1'b1;
      step(pn, qn, dn, W'($urandom));
      check_model($sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
